// File: rtl/hazard_scoreboard.sv
// Per-register pending-latency scoreboard for ID-stage RAW/WAW hazard detection.
// Optional perf counters are enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int MAX_LAT    = 4,
    localparam int CW        = $clog2(MAX_LAT + 1),
    localparam int NREG      = 2 ** REG_ADDR_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          id_valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_i,
    input  logic [NUM_SRC-1:0]            id_rs_use_i,
    input  logic                          id_we_i,
    input  logic [REG_ADDR_W-1:0]         id_rd_i,
    input  logic [CW-1:0]                 id_lat_i,
    input  logic                          flush_i,
    output logic                          stall_o,
    output logic                          pc_write_o,
    output logic                          if_id_write_o,
    output logic                          bubble_o,
`ifdef HAZARD_PERF_EN
    output logic [31:0]                   perf_stall_cnt_o,
    output logic [15:0]                   perf_waw_cnt_o,
`endif
    output logic [NUM_SRC-1:0]            haz_src_o
);

    logic [CW-1:0]      cnt_reg [NREG];
    logic [CW-1:0]      lat_eff;
    logic [NUM_SRC-1:0] raw;
    logic               waw;
    logic               hazard;
    logic               issue;

    assign lat_eff = (id_lat_i > CW'(MAX_LAT)) ? CW'(MAX_LAT) : id_lat_i;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_ADDR_W-1:0] rs;
            assign rs      = id_rs_i[gi*REG_ADDR_W +: REG_ADDR_W];
            assign raw[gi] = id_valid_i & id_rs_use_i[gi] & (rs != '0) & (cnt_reg[rs] != '0);
        end
    endgenerate

    // A younger write may not complete before an older in-flight write to the same rd.
    assign waw    = id_valid_i & id_we_i & (id_rd_i != '0) & (cnt_reg[id_rd_i] > lat_eff);
    assign hazard = ~flush_i & ((|raw) | waw);
    assign issue  = id_valid_i & ~flush_i & ~hazard;

    // Outputs are held inactive while reset is asserted.
    assign stall_o       = rst_i & hazard;
    assign pc_write_o    = ~stall_o;
    assign if_id_write_o = ~stall_o;
    assign bubble_o      = rst_i & (hazard | flush_i);
    assign haz_src_o     = (rst_i & ~flush_i) ? raw : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_reg[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                // A fresh issue to r overrides the countdown; x0 is never recorded.
                if (issue && id_we_i && (r != 0) && (id_rd_i == REG_ADDR_W'(r))) begin
                    cnt_reg[r] <= lat_eff;
                end else if (cnt_reg[r] != '0) begin
                    cnt_reg[r] <= cnt_reg[r] - CW'(1);
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_stall_cnt_o <= '0;
            perf_waw_cnt_o   <= '0;
        end else begin
            if (stall_o && (perf_stall_cnt_o != '1)) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
            if (waw && stall_o && (perf_waw_cnt_o != '1)) begin
                perf_waw_cnt_o <= perf_waw_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [9:0]  id_rs_i;
    logic [1:0]  id_rs_use_i;
    logic        id_we_i;
    logic [4:0]  id_rd_i;
    logic [2:0]  id_lat_i;
    logic        flush_i;
    logic        stall_o;
    logic        pc_write_o;
    logic        if_id_write_o;
    logic        bubble_o;
    logic [1:0]  haz_src_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [15:0] perf_waw_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    hazard_scoreboard dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .id_valid_i       (id_valid_i),
        .id_rs_i          (id_rs_i),
        .id_rs_use_i      (id_rs_use_i),
        .id_we_i          (id_we_i),
        .id_rd_i          (id_rd_i),
        .id_lat_i         (id_lat_i),
        .flush_i          (flush_i),
        .stall_o          (stall_o),
        .pc_write_o       (pc_write_o),
        .if_id_write_o    (if_id_write_o),
        .bubble_o         (bubble_o),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_waw_cnt_o   (perf_waw_cnt_o),
`endif
        .haz_src_o        (haz_src_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                          input logic [1:0] su, input logic we, input logic [4:0] rd,
                          input logic [2:0] lat, input logic fl);
        id_valid_i  = v;
        id_rs_i     = {r1, r0};
        id_rs_use_i = su;
        id_we_i     = we;
        id_rd_i     = rd;
        id_lat_i    = lat;
        flush_i     = fl;
        $display("t=%0t id v=%0b rs0=%0d rs1=%0d use=%b we=%0b rd=%0d lat=%0d flush=%0b",
                 $time, v, r0, r1, su, we, rd, lat, fl);
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 3'd0, 1'b0);
    endtask

    // Holds current inputs and counts cycles with stall_o high (bounded).
    task automatic count_stalls(output int n);
        n = 0;
        while (stall_o === 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        rst_i = 1'b0;
        set_id(1'b1, 5'd5, 5'd5, 2'b11, 1'b1, 5'd5, 3'd4, 1'b1);
        tick();
        tick();
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
        checks++; if (pc_write_o !== 1'b1) begin errors++; $display("FAIL reset_pc_write got %b want 1", pc_write_o); end
        checks++; if (if_id_write_o !== 1'b1) begin errors++; $display("FAIL reset_if_id got %b want 1", if_id_write_o); end
        checks++; if (bubble_o !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", bubble_o); end
        checks++; if (haz_src_o !== 2'b00) begin errors++; $display("FAIL reset_haz_src got %b want 00", haz_src_o); end
`ifdef HAZARD_PERF_EN
        checks++; if (perf_stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d want 0", perf_stall_cnt_o); end
`endif
        idle();
        rst_i = 1'b1;
        tick();
        // Reader of a register right after reset never stalls.
        set_id(1'b1, 5'd5, 5'd5, 2'b11, 1'b0, 5'd0, 3'd0, 1'b0);
        #1;
        count_stalls(n);
        checks++; if (n !== 0) begin errors++; $display("FAIL post_reset_read stalls got %0d want 0", n); end
        tick();
        idle();
    endtask

    task automatic test_load_use();
        int n;
`ifdef HAZARD_PERF_EN
        logic [31:0] p0;
`endif
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 3'd1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
        #1;
`ifdef HAZARD_PERF_EN
        p0 = perf_stall_cnt_o;
`endif
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall_o); end
        checks++; if (pc_write_o !== 1'b0) begin errors++; $display("FAIL lu_pc_write got %b want 0", pc_write_o); end
        checks++; if (if_id_write_o !== 1'b0) begin errors++; $display("FAIL lu_if_id got %b want 0", if_id_write_o); end
        checks++; if (bubble_o !== 1'b1) begin errors++; $display("FAIL lu_bubble got %b want 1", bubble_o); end
        checks++; if (haz_src_o !== 2'b01) begin errors++; $display("FAIL lu_haz_src got %b want 01", haz_src_o); end
        count_stalls(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL lu_stall_cycles got %0d want 1", n); end
        checks++; if (bubble_o !== 1'b0) begin errors++; $display("FAIL lu_release_bubble got %b want 0", bubble_o); end
`ifdef HAZARD_PERF_EN
        checks++; if (perf_stall_cnt_o - p0 !== 32'd1) begin errors++; $display("FAIL lu_perf delta got %0d want 1", perf_stall_cnt_o - p0); end
`endif
        tick();
        idle();
        tick();
    endtask

    task automatic test_alu_chain();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 3'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd3, 2'b10, 1'b1, 5'd12, 3'd0, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", stall_o); end
        checks++; if (haz_src_o !== 2'b00) begin errors++; $display("FAIL alu_haz_src got %b want 00", haz_src_o); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_multicycle();
        int n;
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 3'd4, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
        #1;
        count_stalls(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL mc_direct stalls got %0d want 4", n); end
        tick();
        // rd7 lat4, one independent instr, one idle cycle, then dependent: 2 stalls left.
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 3'd4, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 3'd0, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mc_indep stall got %b want 0", stall_o); end
        tick();
        idle();
        tick();
        set_id(1'b1, 5'd0, 5'd7, 2'b10, 1'b0, 5'd0, 3'd0, 1'b0);
        #1;
        checks++; if (haz_src_o !== 2'b10) begin errors++; $display("FAIL mc_haz_src got %b want 10", haz_src_o); end
        count_stalls(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL mc_late stalls got %0d want 2", n); end
        tick();
        // Latency 7 is clamped to 4.
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd10, 3'd7, 1'b0);
        tick();
        set_id(1'b1, 5'd10, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
        #1;
        count_stalls(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL mc_clamp stalls got %0d want 4", n); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_waw();
        int n;
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 3'd3, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 3'd0, 1'b0);
        #1;
        checks++; if (haz_src_o !== 2'b00) begin errors++; $display("FAIL waw_haz_src got %b want 00", haz_src_o); end
        count_stalls(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL waw_lat0 stalls got %0d want 3", n); end
        tick();
        set_id(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL waw_after_issue stall got %b want 0", stall_o); end
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 3'd3, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 3'd3, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL waw_equal_lat stall got %b want 0", stall_o); end
        tick();
        set_id(1'b1, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
        #1;
        count_stalls(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL waw_second_write stalls got %0d want 3", n); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_flush();
        int n;
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd8, 3'd2, 1'b0);
        tick();
        // Hazard on rs8, flushed; its write to rd8/rd11 must not be recorded.
        set_id(1'b1, 5'd8, 5'd0, 2'b01, 1'b1, 5'd11, 3'd4, 1'b1);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL fl_stall got %b want 0", stall_o); end
        checks++; if (bubble_o !== 1'b1) begin errors++; $display("FAIL fl_bubble got %b want 1", bubble_o); end
        checks++; if (pc_write_o !== 1'b1) begin errors++; $display("FAIL fl_pc_write got %b want 1", pc_write_o); end
        checks++; if (if_id_write_o !== 1'b1) begin errors++; $display("FAIL fl_if_id got %b want 1", if_id_write_o); end
        checks++; if (haz_src_o !== 2'b00) begin errors++; $display("FAIL fl_haz_src got %b want 00", haz_src_o); end
        tick();
        set_id(1'b1, 5'd8, 5'd11, 2'b11, 1'b0, 5'd0, 3'd0, 1'b0);
        #1;
        checks++; if (haz_src_o !== 2'b01) begin errors++; $display("FAIL fl_after haz_src got %b want 01", haz_src_o); end
        count_stalls(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL fl_after stalls got %0d want 1", n); end
        tick();
        // x0 as destination and source never hazards.
        set_id(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 3'd4, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 3'd0, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL x0 stall got %b want 0", stall_o); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 3'd3, 1'b0);
        tick();
        set_id(1'b1, 5'd6, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rm_pre stall got %b want 1", stall_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rm_forced stall got %b want 0", stall_o); end
        checks++; if (pc_write_o !== 1'b1) begin errors++; $display("FAIL rm_forced pc_write got %b want 1", pc_write_o); end
        checks++; if (bubble_o !== 1'b0) begin errors++; $display("FAIL rm_forced bubble got %b want 0", bubble_o); end
        checks++; if (haz_src_o !== 2'b00) begin errors++; $display("FAIL rm_forced haz_src got %b want 00", haz_src_o); end
        tick();
        rst_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rm_release stall got %b want 0", stall_o); end
`ifdef HAZARD_PERF_EN
        checks++; if (perf_stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rm_perf got %0d want 0", perf_stall_cnt_o); end
`endif
        tick();
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst_i = 1'b0;
        test_reset();
        test_load_use();
        test_alu_chain();
        test_multicycle();
        test_waw();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
